// File: rtl/serial_pattern_pkg.sv
// Shared definitions for the serial pattern transmitter and the detector-side benches.
// State encodings are fixed so other blocks can decode them directly.
package serial_pattern_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    DONE   = 2'b10,
    PARITY = 2'b11
  } state_t;

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Load/ready word handshake and serial-side status lines of serial_pattern_tx.
// The master side drives Load/Data; the slave side (the transmitter) drives the rest.
interface serial_pattern_tx_if
  import serial_pattern_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             Load;
  logic [WIDTH-1:0] Data;
  logic             Ready;
  logic             Out1;
  logic             Busy;
  logic             Done;

  modport master (
    output Load,
    output Data,
    input  Ready,
    input  Out1,
    input  Busy,
    input  Done
  );

  modport slave (
    input  Load,
    input  Data,
    output Ready,
    output Out1,
    output Busy,
    output Done
  );

endinterface

// File: rtl/serial_pattern_shreg.sv
// Loadable left-shift register with zero fill; msb is the bit currently on the line.
// load takes priority over shift.
module serial_pattern_shreg
  import serial_pattern_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             msb
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = q[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// MSB-first parallel-to-serial transmitter with a Moore control FSM and bit counter.
// Optional trailing even-parity bit when SERIAL_PATTERN_TX_PARITY_EN is defined.
module serial_pattern_tx
  import serial_pattern_pkg::*;
#(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic               CLK,
  input  logic               RST,
  serial_pattern_tx_if.slave bus
);

  localparam int              CW      = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_MAX = CW'(WIDTH - 1);

  state_t          state;
  state_t          next_state;
  logic [CW-1:0]   cnt;
  logic            load_en;
  logic            shift_en;
  logic            msb;
  logic            out1;

  serial_pattern_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .CLK   (CLK),
    .RST   (RST),
    .load  (load_en),
    .shift (shift_en),
    .d     (bus.Data),
    .msb   (msb)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The counter is reloaded only on acceptance, so it cannot wrap mid-word.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (load_en) begin
      cnt <= CNT_MAX;
    end else if (shift_en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  logic par_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_q <= 1'b0;
    end else if (load_en) begin
      par_q <= ^bus.Data;
    end
  end
`endif

  always_comb begin
    next_state = state;
    load_en    = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Load) begin
          load_en    = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt == '0) begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
          next_state = PARITY;
`else
          next_state = DONE;
`endif
        end
      end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      PARITY:  next_state = DONE;
`endif
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Out1 depends only on registered state, so Load/Data never reach the line directly.
  always_comb begin
    out1 = IDLE_LEVEL;
    case (state)
      SHIFT:   out1 = msb;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      PARITY:  out1 = par_q;
`endif
      default: out1 = IDLE_LEVEL;
    endcase
  end

  assign bus.Out1  = out1;
  assign bus.Ready = (state == IDLE);
  assign bus.Busy  = (state != IDLE);
  assign bus.Done  = (state == DONE);

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx: directed and random words against a per-cycle
// expected-waveform model; honours SERIAL_PATTERN_TX_PARITY_EN when defined.
module tb_serial_pattern_tx;
  import serial_pattern_pkg::*;

  localparam int   W          = DEFAULT_WIDTH;
  localparam logic IDLE_LEVEL = 1'b0;

  typedef struct packed {
    logic out1;
    logic ready;
    logic busy;
    logic done;
  } cyc_t;

  localparam cyc_t IDLE_CYC = cyc_t'{IDLE_LEVEL, 1'b1, 1'b0, 1'b0};

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  cyc_t expQ[$];

  serial_pattern_tx_if #(.WIDTH(W)) bus ();

  serial_pattern_tx #(
    .WIDTH      (W),
    .IDLE_LEVEL (IDLE_LEVEL)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input cyc_t e);
    checkOutput({tag, ".Out1"},  bus.Out1,  e.out1);
    checkOutput({tag, ".Ready"}, bus.Ready, e.ready);
    checkOutput({tag, ".Busy"},  bus.Busy,  e.busy);
    checkOutput({tag, ".Done"},  bus.Done,  e.done);
  endtask

  // Expected line waveform from the cycle after acceptance until Ready returns.
  function automatic void buildExpect(input logic [W-1:0] word);
    expQ.delete();
    for (int i = W - 1; i >= 0; i--) begin
      expQ.push_back(cyc_t'{word[i], 1'b0, 1'b1, 1'b0});
    end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    expQ.push_back(cyc_t'{^word, 1'b0, 1'b1, 1'b0});
`endif
    expQ.push_back(cyc_t'{IDLE_LEVEL, 1'b0, 1'b1, 1'b1});
    expQ.push_back(IDLE_CYC);
  endfunction

  // Called at a negedge; returns at the negedge of the first idle cycle after the word.
  task automatic applyStimulus(input logic [W-1:0] word, input bit holdLoad,
                               input bit noisy, input string tag);
    int waitCycles = 0;
    while (bus.Ready !== 1'b1 && waitCycles < 3 * W) begin
      @(negedge CLK);
      waitCycles++;
    end
    if (bus.Ready !== 1'b1) checkOutput({tag, ".ready_wait"}, bus.Ready, 1'b1);
    bus.Load = 1'b1;
    bus.Data = word;
    buildExpect(word);
    @(negedge CLK);
    for (int i = 0; i < expQ.size(); i++) begin
      checkAll($sformatf("%s[%0d]", tag, i), expQ[i]);
      if (i == expQ.size() - 1) begin
        bus.Load = holdLoad;
      end else begin
        bus.Load = holdLoad || (noisy && ($urandom_range(0, 1) == 1));
        bus.Data = noisy ? {W{1'b1}} : W'($urandom);
        @(negedge CLK);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.Load = 1'b1;
    bus.Data = W'($urandom);
    RST      = 1'b0;

    // Reset holds the transmitter idle even with Load asserted.
    repeat (4) begin
      @(negedge CLK);
      checkAll("reset", IDLE_CYC);
      bus.Data = W'($urandom);
    end
    RST = 1'b1;

    applyStimulus(8'hA5, 1'b0, 1'b1, "a5");
    @(negedge CLK);
    checkAll("a5.no_second", IDLE_CYC);

    // Abort 8'hF0 during its 4th bit.
    bus.Load = 1'b1;
    bus.Data = 8'hF0;
    @(negedge CLK);
    bus.Load = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("f0.bit4.Out1", bus.Out1, 1'b1);
    checkOutput("f0.bit4.Busy", bus.Busy, 1'b1);
    #2 RST = 1'b0;
    #1 checkAll("f0.abort", IDLE_CYC);
    bus.Load = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      checkAll("f0.in_reset", IDLE_CYC);
      bus.Data = W'($urandom);
    end
    RST      = 1'b1;
    bus.Load = 1'b0;
    @(negedge CLK);
    checkAll("f0.after_reset", IDLE_CYC);

    applyStimulus(8'h3C, 1'b0, 1'b0, "3c");

    applyStimulus(8'h80, 1'b1, 1'b0, "b2b0");
    applyStimulus(8'h01, 1'b1, 1'b0, "b2b1");
    bus.Load = 1'b0;
    @(negedge CLK);
    checkAll("b2b.idle", IDLE_CYC);

    repeat (20) begin
      applyStimulus(W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd");
    end
    bus.Load = 1'b0;
    @(negedge CLK);
    checkAll("rnd.idle", IDLE_CYC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
Parallel-to-serial bit-stream transmitter. Accepts a WIDTH-bit word through a load/ready handshake and drives it MSB-first, one bit per CLK, onto a single serial line. It feeds the single-bit In1 input of the team's Moore sequence-detector FSMs, so benches and top-levels can produce deterministic patterns. Moore-style control FSM with a shift register and a bit counter.

Parameters:
- WIDTH, default 8: data word width in bits; must be >= 2.
- IDLE_LEVEL, default 1'b0: level driven on Out1 whenever no bit is being transmitted.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  reset; asynchronous, active-low.
- Load  input  1  request to transmit Data; sampled only while Ready=1.
- Data  input  WIDTH  word to transmit; captured on the accepting edge.
- Ready  output  1  1 only in IDLE; a word is accepted on an edge where Load=1 and Ready=1.
- Out1  output  1  serial bit stream.
- Busy  output  1  1 in every state except IDLE.
- Done  output  1  one-cycle pulse after the last transmitted bit.

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE, shift register=0, counter=0. Outputs immediately become Ready=1, Busy=0, Done=0, Out1=IDLE_LEVEL. Reset during a transfer aborts it with no Done pulse.
- All outputs are decoded from registered state and the shift register only (Moore). No input reaches an output combinationally.
- States:
  - IDLE: Ready=1, Out1=IDLE_LEVEL. Load=1 at an edge loads Data into the shift register, sets counter=WIDTH-1 and moves to SHIFT. Otherwise the FSM stays in IDLE.
  - SHIFT: Out1=shift register MSB. Each edge shifts left by one with 0 fill and decrements the counter. When counter==0 at an edge, go to DONE (or to PARITY when the optional feature is enabled).
  - DONE: Done=1, Out1=IDLE_LEVEL, Ready=0. Unconditionally go to IDLE on the next edge.
  - Any illegal state encoding: go to IDLE.
- Timing, with a word accepted at edge k:
  - data bits appear on Out1 in cycles k+1 .. k+WIDTH;
  - Done=1 in cycle k+WIDTH+1;
  - Ready=1 again in cycle k+WIDTH+2.
  - With Load held high, back-to-back words are separated by exactly 2 idle-level cycles (DONE, IDLE).
- Load while Ready=0 is ignored and not queued. Changes to Data after acceptance have no effect.
- Counter width is $clog2(WIDTH). It never wraps, because it is reloaded only in IDLE.

Optional Feature:
- Macro: SERIAL_PATTERN_TX_PARITY_EN.
- Defined:
  - An extra state PARITY follows SHIFT for one cycle, with Out1 = even parity (XOR) of the captured word.
  - The parity value is computed and registered at acceptance.
  - Done moves to cycle k+WIDTH+2 and Ready to cycle k+WIDTH+3.
- Undefined: no PARITY state, no parity register, and timing as in Behaviour.

Decomposition:
- Shared package/header (serial_pattern_pkg): state encodings IDLE=2'b00, SHIFT=2'b01, DONE=2'b10, PARITY=2'b11, plus the default WIDTH constant. The detector-side benches reuse these.
- One natural sub-module: serial_pattern_shreg, the loadable left-shift register with MSB output. It has ports CLK, RST, load, shift, d, msb.
- The FSM and counter stay in the top module.

Test Plan:
- Reset check: hold RST=0 with Load=1 and random Data -> Ready=1, Busy=0, Done=0, Out1=0 throughout. Release RST -> first accept on the next edge.
- Single word: WIDTH=8, Data=8'hA5 accepted at edge k -> Out1 = 1,0,1,0,0,1,0,1 in cycles k+1..k+8; Done=1 only in cycle k+9; Ready=1 in cycle k+10.
- Ignored load: during the 8'hA5 transfer, pulse Load with Data=8'hFF -> stream unchanged, no second transfer starts.
- Mid-transfer reset: drop RST during the 4th bit of 8'hF0 -> Out1=0 and Busy=0 immediately, no Done pulse. Then send 8'h3C -> correct stream 0,0,1,1,1,1,0,0.
- Back-to-back: Load held high with 8'h80 then 8'h01 -> bits 1,0,0,0,0,0,0,0, then 2 cycles at 0, then 0,0,0,0,0,0,0,1. Exactly two Done pulses.
- Parity (macro defined): 8'hA5 -> parity bit 0 in cycle k+9, Done in cycle k+10. 8'h01 -> parity bit 1.
